// File: rtl/dvp_tx_source.sv
// OV5640-style DVP byte transmitter: RGB565 stream in, vsync/href/byte out.
// All cam outputs are registered and trail the frame-timing state by one cycle.
module dvp_tx_source #(
    parameter int DATA_WIDTH    = 8,
    parameter int HTS           = 1896,
    parameter int H_FRONT       = 20,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_LINES  = 10,
    parameter int V_FRONT_LINES = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [15:0]           resolution_width_i,
    input  logic [15:0]           resolution_depth_i,
    input  logic [15:0]           s_pixel_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  cam_vsync_o,
    output logic                  cam_href_o,
    output logic [DATA_WIDTH-1:0] cam_half_pixel_o,
    output logic                  frame_start_o,
    output logic                  frame_done_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  underflow_o,
    output logic                  config_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_VSYNC, ST_VBP, ST_HFP, ST_ACTIVE, ST_HBLANK, ST_VFP
    } state_t;

    localparam logic [31:0] HTS_U      = 32'(HTS);
    localparam logic [31:0] HFRONT_U   = 32'(H_FRONT);
    localparam logic [31:0] HFP_LAST   = 32'(H_FRONT - 1);
    localparam logic [31:0] VSYNC_LAST = 32'(VSYNC_LINES * HTS - 1);
    localparam logic [31:0] VBP_LAST   = 32'(V_BACK_LINES * HTS - 1);
    localparam logic [31:0] VFP_LAST   = 32'(V_FRONT_LINES * HTS - 1);

    state_t                state_q;
    logic [31:0]           cnt_q;
    logic [15:0]           line_q;
    logic [15:0]           width_q;
    logic [15:0]           depth_q;
    logic [15:0]           frame_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] low_q;
    logic                  vsync_q;
    logic                  href_q;
    logic                  frame_start_q;
    logic                  frame_done_q;
    logic                  done_pend_q;
    logic                  underflow_q;
    logic                  config_err_q;

    logic [31:0] cfg_act_len;
    logic [31:0] act_len;
    logic [31:0] act_last;
    logic [31:0] hblank_len;
    logic [31:0] hblank_last;
    logic        cfg_ok;
    logic        last_line;
    logic        phase0;
    logic [15:0] pix_in;

    always_comb begin
        cfg_act_len = {15'd0, resolution_width_i, 1'b0};
        cfg_ok      = (resolution_width_i != 16'd0) && (resolution_depth_i != 16'd0) &&
                      (cfg_act_len + HFRONT_U <= HTS_U);
        act_len     = {15'd0, width_q, 1'b0};
        act_last    = act_len - 32'd1;
        hblank_len  = HTS_U - HFRONT_U - act_len;
        hblank_last = hblank_len - 32'd1;
        last_line   = (line_q == depth_q - 16'd1);
        phase0      = (state_q == ST_ACTIVE) && !cnt_q[0];
        // A missing pixel is replaced by black so line timing never stalls.
        pix_in      = s_valid_i ? s_pixel_i : 16'h0000;
    end

    assign s_ready_o        = phase0;
    assign cam_vsync_o      = vsync_q;
    assign cam_href_o       = href_q;
    assign cam_half_pixel_o = data_q;
    assign frame_start_o    = frame_start_q;
    assign frame_done_o     = frame_done_q;
    assign frame_cnt_o      = frame_cnt_q;
    assign underflow_o      = underflow_q;
    assign config_err_o     = config_err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 32'd0;
            line_q        <= 16'd0;
            width_q       <= 16'd0;
            depth_q       <= 16'd0;
            frame_cnt_q   <= 16'd0;
            data_q        <= '0;
            low_q         <= '0;
            vsync_q       <= 1'b1;
            href_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            done_pend_q   <= 1'b0;
            underflow_q   <= 1'b0;
            config_err_q  <= 1'b0;
        end else begin
            href_q        <= 1'b0;
            data_q        <= '0;
            vsync_q       <= (state_q == ST_IDLE) || (state_q == ST_VSYNC) || (state_q == ST_VFP);
            frame_start_q <= (state_q == ST_VSYNC) && (cnt_q == 32'd0);
            // Done is held back one extra cycle so it coincides with the next frame_start.
            done_pend_q   <= 1'b0;
            frame_done_q  <= done_pend_q;
            if (done_pend_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        width_q      <= resolution_width_i;
                        depth_q      <= resolution_depth_i;
                        config_err_q <= !cfg_ok;
                        if (cfg_ok) begin
                            state_q <= ST_VSYNC;
                            cnt_q   <= 32'd0;
                        end
                    end
                end
                ST_VSYNC: begin
                    if (cnt_q == VSYNC_LAST) begin
                        state_q <= ST_VBP;
                        cnt_q   <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_VBP: begin
                    if (cnt_q == VBP_LAST) begin
                        state_q <= ST_HFP;
                        cnt_q   <= 32'd0;
                        line_q  <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_HFP: begin
                    if (cnt_q == HFP_LAST) begin
                        state_q <= ST_ACTIVE;
                        cnt_q   <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_ACTIVE: begin
                    href_q <= 1'b1;
                    if (phase0) begin
                        data_q <= DATA_WIDTH'(pix_in[15:8]);
                        low_q  <= DATA_WIDTH'(pix_in[7:0]);
                        if (!s_valid_i) begin
                            underflow_q <= 1'b1;
                        end
                    end else begin
                        data_q <= low_q;
                    end
                    if (cnt_q == act_last) begin
                        cnt_q <= 32'd0;
                        if (hblank_len == 32'd0) begin
                            line_q  <= line_q + 16'd1;
                            state_q <= last_line ? ST_VFP : ST_HFP;
                        end else begin
                            state_q <= ST_HBLANK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_HBLANK: begin
                    if (cnt_q == hblank_last) begin
                        cnt_q   <= 32'd0;
                        line_q  <= line_q + 16'd1;
                        state_q <= last_line ? ST_VFP : ST_HFP;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_VFP: begin
                    if (cnt_q == VFP_LAST) begin
                        cnt_q       <= 32'd0;
                        done_pend_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        if (enable_i) begin
                            width_q      <= resolution_width_i;
                            depth_q      <= resolution_depth_i;
                            config_err_q <= !cfg_ok;
                            if (cfg_ok) begin
                                state_q <= ST_VSYNC;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_tx_source.sv
// Bench for dvp_tx_source on a shrunken timing (HTS=40): byte scoreboard plus
// line/frame timing measurements taken from the output pins.
module tb_dvp_tx_source;

    localparam int HTS     = 40;
    localparam int H_FRONT = 4;
    localparam int VS_L    = 1;
    localparam int VB_L    = 2;
    localparam int VF_L    = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [15:0] width_i;
    logic [15:0] depth_i;
    logic [15:0] s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        fstart;
    logic        fdone;
    logic [15:0] fcnt;
    logic        uflow;
    logic        cerr;

    always #5 clk = ~clk;

    dvp_tx_source #(
        .DATA_WIDTH(8), .HTS(HTS), .H_FRONT(H_FRONT),
        .VSYNC_LINES(VS_L), .V_BACK_LINES(VB_L), .V_FRONT_LINES(VF_L)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .resolution_width_i(width_i), .resolution_depth_i(depth_i),
        .s_pixel_i(s_pixel), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .cam_vsync_o(vsync), .cam_href_o(href), .cam_half_pixel_o(data),
        .frame_start_o(fstart), .frame_done_o(fdone), .frame_cnt_o(fcnt),
        .underflow_o(uflow), .config_err_o(cerr)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          cur_w = 8;
    int          cur_d = 4;
    int          drop_slot = -1;
    int          slot_cnt = 0;
    logic [15:0] pix_cnt = 16'd0;
    int          fs_cnt = 0;
    int          fd_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pixel source: one pixel per ready slot, optionally withholding one slot.
    initial begin
        s_valid = 1'b1;
        s_pixel = 16'd0;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (s_ready) begin
                    if (slot_cnt == drop_slot) begin
                        s_valid = 1'b0;
                        exp_q.push_back(8'h00);
                        exp_q.push_back(8'h00);
                    end else begin
                        s_valid = 1'b1;
                        s_pixel = pix_cnt;
                        exp_q.push_back(pix_cnt[15:8]);
                        exp_q.push_back(pix_cnt[7:0]);
                        pix_cnt = pix_cnt + 16'd1;
                    end
                    slot_cnt++;
                end else begin
                    s_valid = 1'b1;
                    s_pixel = pix_cnt;
                end
            end
        end
    end

    // Output monitor: byte scoreboard and timing measurements.
    initial begin
        logic       prev_href;
        logic       prev_vsync;
        int         t;
        int         run;
        int         last_rise;
        int         last_fs;
        int         frame_lines;
        logic [1:0] en_hist;
        logic [7:0] e;
        prev_href = 1'b0; prev_vsync = 1'b1; t = 0; run = 0;
        last_rise = -1; last_fs = -1; frame_lines = 0; en_hist = 2'b00;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev_href = 1'b0; prev_vsync = 1'b1; run = 0;
                last_rise = -1; last_fs = -1; frame_lines = 0; en_hist = 2'b00;
            end else begin
                t++;
                if (href) begin
                    if (!prev_href) begin
                        if (frame_lines > 0 && last_rise >= 0)
                            check_val("line_period", 32'(t - last_rise), 32'(HTS));
                        last_rise = t;
                        frame_lines++;
                    end
                    run++;
                    if (exp_q.size() == 0) begin
                        check_val("sb_underrun", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("byte", 32'(data), 32'(e));
                    end
                end else begin
                    if (prev_href) begin
                        check_val("href_len", 32'(run), 32'(2 * cur_w));
                        run = 0;
                    end
                    check_val("blank_data", 32'(data), 32'd0);
                end
                if (fstart) begin
                    fs_cnt++;
                    check_val("fs_vsync", 32'(vsync), 32'd1);
                    if (last_fs >= 0)
                        check_val("frame_period", 32'(t - last_fs), 32'((VS_L + VB_L + cur_d + VF_L) * HTS));
                    last_fs = t;
                end
                if (prev_vsync && !vsync && last_fs >= 0)
                    check_val("vsync_width", 32'(t - last_fs), 32'(VS_L * HTS));
                if (fdone) begin
                    fd_cnt++;
                    check_val("frame_lines", 32'(frame_lines), 32'(cur_d));
                    check_val("frame_cnt", 32'(fcnt), 32'(fd_cnt & 16'hFFFF));
                    if (en_hist[1])
                        check_val("b2b_start", 32'(fstart), 32'd1);
                    else
                        check_val("stop_no_start", 32'(fstart), 32'd0);
                    frame_lines = 0;
                end
                prev_href  = href;
                prev_vsync = vsync;
                en_hist    = {en_hist[0], enable_i};
            end
        end
    end

    task automatic tb_reset();
        @(posedge clk); #2;
        reset_i  = 1'b1;
        enable_i = 1'b0;
        @(posedge clk); #2;
        exp_q.delete();
        slot_cnt = 0; pix_cnt = 16'd0; fs_cnt = 0; fd_cnt = 0; drop_slot = -1;
        @(posedge clk); #2;
        reset_i = 1'b0;
    endtask

    task automatic start(input int w, input int d);
        @(posedge clk); #2;
        width_i  = 16'(w);
        depth_i  = 16'(d);
        cur_w    = w;
        cur_d    = d;
        enable_i = 1'b1;
    endtask

    task automatic wait_fd(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && fd_cnt < target; i++) @(posedge clk);
        check_val(tag, 32'(fd_cnt), 32'(target));
        #2;
    endtask

    task automatic wait_href(input int budget, input string tag);
        for (int i = 0; i < budget && !href; i++) @(negedge clk);
        check_val(tag, 32'(href), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; enable_i = 1'b0; width_i = 16'd8; depth_i = 16'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_vsync", 32'(vsync), 32'd1);
        check_val("rst_href", 32'(href), 32'd0);
        check_val("rst_data", 32'(data), 32'd0);
        check_val("rst_ready", 32'(s_ready), 32'd0);
        check_val("rst_fstart", 32'(fstart), 32'd0);
        check_val("rst_fdone", 32'(fdone), 32'd0);
        check_val("rst_fcnt", 32'(fcnt), 32'd0);
        check_val("rst_uflow", 32'(uflow), 32'd0);
        check_val("rst_cerr", 32'(cerr), 32'd0);

        // Nominal stream, two back-to-back frames.
        tb_reset();
        start(8, 4);
        wait_fd(2, 1000, "a_frames");
        repeat (5) @(posedge clk);
        check_val("a_drain", 32'(exp_q.size()), 32'd0);
        check_val("a_pixels", 32'(pix_cnt), 32'd64);
        check_val("a_uflow", 32'(uflow), 32'd0);
        check_val("a_fcnt", 32'(fcnt), 32'd2);

        // Pixel slot 3 withheld: zero bytes, sticky underflow, no timing shift.
        tb_reset();
        drop_slot = 3;
        start(8, 4);
        wait_fd(1, 600, "b_frame1");
        check_val("b_uflow1", 32'(uflow), 32'd1);
        wait_fd(2, 600, "b_frame2");
        repeat (5) @(posedge clk);
        check_val("b_uflow2", 32'(uflow), 32'd1);
        check_val("b_drain", 32'(exp_q.size()), 32'd0);
        check_val("b_pixels", 32'(pix_cnt), 32'd63);

        // Widest legal line: no horizontal blanking.
        tb_reset();
        start(18, 2);
        wait_fd(2, 800, "c_frames");
        repeat (5) @(posedge clk);
        check_val("c_drain", 32'(exp_q.size()), 32'd0);
        check_val("c_pixels", 32'(pix_cnt), 32'd72);

        // One pixel too wide: held in IDLE with config error, then recovers.
        tb_reset();
        start(19, 2);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check_val("cfg_err", 32'(cerr), 32'd1);
        check_val("cfg_vsync", 32'(vsync), 32'd1);
        check_val("cfg_href", 32'(href), 32'd0);
        check_val("cfg_data", 32'(data), 32'd0);
        check_val("cfg_ready", 32'(s_ready), 32'd0);
        check_val("cfg_no_start", 32'(fs_cnt), 32'd0);
        @(posedge clk); #2;
        width_i = 16'd8;
        cur_w   = 8;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("cfg_clear", 32'(cerr), 32'd0);
        check_val("cfg_started", 32'(fs_cnt), 32'd1);

        // Enable dropped mid-line: frame completes, then IDLE.
        tb_reset();
        start(8, 4);
        wait_href(300, "d_href_seen");
        repeat (5) @(posedge clk);
        #2 enable_i = 1'b0;
        wait_fd(1, 600, "d_done");
        repeat (400) @(posedge clk);
        @(negedge clk);
        check_val("d_fd_cnt", 32'(fd_cnt), 32'd1);
        check_val("d_fs_cnt", 32'(fs_cnt), 32'd1);
        check_val("d_fcnt", 32'(fcnt), 32'd1);
        check_val("d_vsync", 32'(vsync), 32'd1);
        check_val("d_href", 32'(href), 32'd0);

        // Reset during ACTIVE of frame 2, enable held.
        tb_reset();
        start(8, 4);
        wait_fd(1, 600, "e_frame1");
        wait_href(300, "e_href_seen");
        @(posedge clk); #2;
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("e_href", 32'(href), 32'd0);
        check_val("e_data", 32'(data), 32'd0);
        check_val("e_vsync", 32'(vsync), 32'd1);
        check_val("e_fcnt", 32'(fcnt), 32'd0);
        check_val("e_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        slot_cnt = 0; pix_cnt = 16'd0; fs_cnt = 0; fd_cnt = 0;
        @(posedge clk); #2;
        reset_i = 1'b0;
        for (int i = 0; i < 20 && fs_cnt < 1; i++) @(posedge clk);
        check_val("e_restart", 32'(fs_cnt), 32'd1);
        wait_fd(1, 600, "e_fresh_frame");
        repeat (5) @(posedge clk);
        check_val("e_drain", 32'(exp_q.size()), 32'd0);
        check_val("e_pixels", 32'(pix_cnt), 32'd32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvp_tx_source.md
# dvp_tx_source

Synthesizable OV5640-style DVP transmitter: takes RGB565 pixels from a valid/ready stream and emits camera-format `vsync`/`href`/byte data, one byte per `clk_i` cycle, high byte first. It mirrors the frame timing our DVP receiver is built for (HTS-based lines, VSYNC high during vertical blanking). It sits in front of `DVP_RX_TX_core` as an on-chip camera emulator for hardware bring-up and loopback, and is the byte-level reference source for RX benches.

## Interface
- `DATA_WIDTH`, 8, DVP byte width
- `HTS`, 1896, total cycles per line (front porch + active + blanking)
- `H_FRONT`, 20, `href`-low cycles before active bytes in each line
- `VSYNC_LINES`, 3, lines of VSYNC pulse at frame start
- `V_BACK_LINES`, 10, lines between VSYNC fall and first active line
- `V_FRONT_LINES`, 10, lines after the last active line, `vsync`=1
- `clk_i` in 1: single clock; each cycle is one PCLK period. Only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `enable_i` in 1: run frames continuously while high.
- `resolution_width_i` in 16: active pixels per line, latched at frame start.
- `resolution_depth_i` in 16: active lines per frame, latched at frame start.
- `s_pixel_i` in 16: RGB565 pixel.
- `s_valid_i` in 1: `s_pixel_i` valid.
- `s_ready_o` out 1: pixel consumed this cycle when `s_valid_i`=1.
- `cam_vsync_o` out 1: DVP VSYNC, active high during vertical blanking.
- `cam_href_o` out 1: DVP HREF, high for the `2*width` active bytes.
- `cam_half_pixel_o` out DATA_WIDTH: DVP byte.
- `frame_start_o` out 1: one-cycle pulse on VSYNC entry.
- `frame_done_o` out 1: one-cycle pulse at the end of V_FRONT.
- `frame_cnt_o` out 16: frames completed, wraps at 0xFFFF→0.
- `underflow_o` out 1: sticky; a pixel was needed and `s_valid_i`=0.
- `config_err_o` out 1: latched resolution is illegal.

## Operation
- States: IDLE → VSYNC (VSYNC_LINES*HTS cycles) → VBP (V_BACK_LINES*HTS) → per line {HFP (H_FRONT), ACTIVE (2*width), HBLANK (HTS−H_FRONT−2*width)} × depth → VFP (V_FRONT_LINES*HTS) → VSYNC if `enable_i`, else IDLE.
- IDLE: `vsync`=1, `href`=0, data=0. Leaves IDLE when `enable_i`=1. Latches the width and depth, then checks them.
- Illegal configuration: width=0, depth=0, or 2*width+H_FRONT > HTS. Result: stay in IDLE with `config_err_o`=1. The flag clears on the next legal latch.
- `enable_i` is sampled only in IDLE and at the end of VFP. Deasserting it mid-frame lets the frame complete.
- ACTIVE byte phase toggles each cycle. Phase 0 asserts `s_ready_o` combinationally and captures the pixel. The high byte goes out on phase 0 and the low byte on phase 1.
- Underflow: phase 0 with `s_valid_i`=0 emits pixel 0x0000 and sets `underflow_o`. No pixel is consumed, and timing never stalls.
- `s_ready_o`=0 outside ACTIVE phase 0.
- Line and frame counters are at least 16 bits; the VSYNC, VBP and VFP phase counters are at least 32 bits (HTS*lines). All counts are unsigned.
- `frame_cnt_o` increments on `frame_done_o`.

## Timing
- Reset values: `cam_vsync_o`=1, `cam_href_o`=0, `cam_half_pixel_o`=0, `s_ready_o`=0, `frame_start_o`=0, `frame_done_o`=0, `frame_cnt_o`=0, `underflow_o`=0, `config_err_o`=0. State is IDLE.
- Reset mid-frame: IDLE on the next cycle; no partial-line continuation.
- Cam outputs are registered and lag the state by exactly 1 cycle. The pixel accepted in cycle N appears as the high byte in N+1 and the low byte in N+2.
- `href` rises together with the first high byte and falls after exactly 2*width bytes.
- Line period is exactly HTS cycles.
- Frame period is (VSYNC_LINES + V_BACK_LINES + depth + V_FRONT_LINES) * HTS cycles.
- `vsync` falls exactly VSYNC_LINES*HTS cycles after `frame_start_o`.
- Back-to-back frames: `vsync` stays high continuously through VFP and the next VSYNC. `frame_done_o` and the next `frame_start_o` occur in the same cycle.
- Boundary case 2*width+H_FRONT = HTS: HBLANK length 0, so the next HFP starts immediately.

## Test plan
- Small config (HTS=40, H_FRONT=4, VSYNC_LINES=1, V_BACK_LINES=2, V_FRONT_LINES=2, width=8, depth=4), stream always valid with incrementing pixels 0x0000.. → 16 bytes per line, `href` high 16 cycles per 40, 4 lines per frame, bytes 00,00,00,01,…, frame period 360 cycles, `underflow_o`=0.
- Same config, `s_valid_i` dropped for pixel 3 → bytes for that slot are 00,00, `underflow_o`=1 and stays 1, later pixels are not shifted in timing.
- width=18 with HTS=40, H_FRONT=4 (36+4 = 40, legal, HBLANK=0) → lines are contiguous. width=19 → `config_err_o`=1, outputs stay at the IDLE values.
- `enable_i` cleared mid-line of frame 1 → frame 1 completes, one `frame_done_o`, `frame_cnt_o`=1, return to IDLE, `vsync`=1.
- `reset_i` pulsed during ACTIVE → next cycle `href`=0, data=0, `vsync`=1, counters 0. With `enable_i` held, a fresh VSYNC starts after reset release.
- Default parameters, 640x480 from an image file, looped into `DVP_RX_TX_core` → RX output frame matches the input image pixel for pixel.
